// File: rtl/intersection_sequencer.sv
// Four-way intersection sequencer: NS/EW right-of-way with all-red clearance and safe emergency preemption.
// Lights are a zero-latency decode of the registered state; PED_WALK_EN adds an all-red pedestrian WALK phase.
module intersection_sequencer #(
    parameter int T_LEFT   = 4,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
`ifdef PED_WALK_EN
    parameter int T_WALK   = 6,
`endif
    parameter int T_ALLRED = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       emergency,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [3:0] ns_light,
    output logic [3:0] ew_light,
    output logic       all_stop
);

    localparam logic [3:0] L_LEFT   = 4'b1001;
    localparam logic [3:0] L_GREEN  = 4'b0100;
    localparam logic [3:0] L_YELLOW = 4'b0010;
    localparam logic [3:0] L_RED    = 4'b0001;

    localparam logic [4:0] C_LEFT_END   = 5'(T_LEFT - 1);
    localparam logic [4:0] C_GREEN_END  = 5'(T_GREEN - 1);
    localparam logic [4:0] C_YELLOW_END = 5'(T_YELLOW - 1);
    localparam logic [4:0] C_ALLRED_END = 5'(T_ALLRED - 1);
`ifdef PED_WALK_EN
    localparam logic [4:0] C_WALK_END   = 5'(T_WALK - 1);
`endif

    typedef enum logic [3:0] {
        ST_ALLRED,
        ST_NS_LEFT,
        ST_NS_GREEN,
        ST_NS_YELLOW,
        ST_EW_LEFT,
        ST_EW_GREEN,
        ST_EW_YELLOW,
`ifdef PED_WALK_EN
        ST_WALK,
`endif
        ST_PREEMPT
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       r_next_dir;
    logic       r_preempt_pending;

    state_t     w_state_nxt;
    state_t     w_left_st;
    logic [4:0] w_cnt_nxt;
    logic       w_dir_nxt;
    logic       w_pend_nxt;

`ifdef PED_WALK_EN
    logic       r_ped_pending;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_ALLRED;
            r_cnt             <= 5'd0;
            r_next_dir        <= 1'b0;
            r_preempt_pending <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_cnt             <= w_cnt_nxt;
            r_next_dir        <= w_dir_nxt;
            r_preempt_pending <= w_pend_nxt;
        end
    end

`ifdef PED_WALK_EN
    // Entry into WALK consumes the request; a request seen on that same edge is dropped with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_pending <= 1'b0;
        end else if (w_state_nxt == ST_WALK && r_state != ST_WALK) begin
            r_ped_pending <= 1'b0;
        end else if (ped_req) begin
            r_ped_pending <= 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 5'd1;
        w_dir_nxt   = r_next_dir;
        w_pend_nxt  = r_preempt_pending;
        w_left_st   = r_next_dir ? ST_EW_LEFT : ST_NS_LEFT;
        ns_light    = L_RED;
        ew_light    = L_RED;
        all_stop    = 1'b0;
`ifdef PED_WALK_EN
        walk        = 1'b0;
`endif

        case (r_state)
            ST_ALLRED: begin
                if (emergency) begin
                    w_state_nxt = ST_PREEMPT;
                end else if (r_cnt == C_ALLRED_END) begin
`ifdef PED_WALK_EN
                    if (r_ped_pending) w_state_nxt = ST_WALK;
                    else
`endif
                    w_state_nxt = w_left_st;
                end
            end
            ST_NS_LEFT: begin
                ns_light = L_LEFT;
                if (emergency) begin
                    w_state_nxt = ST_NS_YELLOW;
                    w_pend_nxt  = 1'b1;
                end else if (r_cnt == C_LEFT_END) begin
                    w_state_nxt = ST_NS_GREEN;
                end
            end
            ST_NS_GREEN: begin
                ns_light = L_GREEN;
                if (emergency) begin
                    w_state_nxt = ST_NS_YELLOW;
                    w_pend_nxt  = 1'b1;
                end else if (r_cnt == C_GREEN_END) begin
                    w_state_nxt = ST_NS_YELLOW;
                end
            end
            ST_EW_LEFT: begin
                ew_light = L_LEFT;
                if (emergency) begin
                    w_state_nxt = ST_EW_YELLOW;
                    w_pend_nxt  = 1'b1;
                end else if (r_cnt == C_LEFT_END) begin
                    w_state_nxt = ST_EW_GREEN;
                end
            end
            ST_EW_GREEN: begin
                ew_light = L_GREEN;
                if (emergency) begin
                    w_state_nxt = ST_EW_YELLOW;
                    w_pend_nxt  = 1'b1;
                end else if (r_cnt == C_GREEN_END) begin
                    w_state_nxt = ST_EW_YELLOW;
                end
            end
            // Yellow always runs to completion; an emergency only redirects where it exits to.
            ST_NS_YELLOW, ST_EW_YELLOW: begin
                if (r_state == ST_NS_YELLOW) ns_light = L_YELLOW;
                else                         ew_light = L_YELLOW;
                w_pend_nxt = r_preempt_pending | emergency;
                if (r_cnt == C_YELLOW_END) begin
                    w_dir_nxt = ~r_next_dir;
                    if (r_preempt_pending | emergency) begin
                        w_state_nxt = ST_PREEMPT;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_ALLRED;
                    end
                end
            end
`ifdef PED_WALK_EN
            ST_WALK: begin
                walk = 1'b1;
                if (emergency) begin
                    w_state_nxt = ST_PREEMPT;
                end else if (r_cnt == C_WALK_END) begin
                    w_state_nxt = w_left_st;
                end
            end
`endif
            ST_PREEMPT: begin
                all_stop = 1'b1;
                if (!emergency) w_state_nxt = ST_ALLRED;
            end
            default: begin
                w_state_nxt = ST_ALLRED;
            end
        endcase

        if (w_state_nxt != r_state || r_state == ST_PREEMPT) w_cnt_nxt = 5'd0;
    end

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer: normal cycle, preemption cases, async reset, optional walk.
module tb_intersection_sequencer;

    localparam logic [3:0] R = 4'b0001;
    localparam logic [3:0] L = 4'b1001;
    localparam logic [3:0] G = 4'b0100;
    localparam logic [3:0] Y = 4'b0010;

    logic       clk;
    logic       rst;
    logic       emergency;
    logic [3:0] ns_light;
    logic [3:0] ew_light;
    logic       all_stop;
`ifdef PED_WALK_EN
    logic       ped_req;
    logic       walk;
`endif

    int total = 0;
    int bad   = 0;

    intersection_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .emergency (emergency),
`ifdef PED_WALK_EN
        .ped_req   (ped_req),
        .walk      (walk),
`endif
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .all_stop  (all_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, want);
        end
    endtask

    // Advance one cycle and sample 2 time units after the edge; the safety invariant is checked every cycle.
    task automatic tick();
        @(posedge clk);
        #2;
        total++;
        assert (ns_light === R || ew_light === R) else begin
            bad++;
            $error("FAIL invariant: observed ns=%b ew=%b expected one head = 0001", ns_light, ew_light);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [3:0] ns_e, input logic [3:0] ew_e, input logic stop_e);
        chk({tag, "_ns"}, ns_light, ns_e);
        chk({tag, "_ew"}, ew_light, ew_e);
        chk({tag, "_stop"}, {3'b000, all_stop}, {3'b000, stop_e});
    endtask

    task automatic run(input int n, input logic [3:0] ns_e, input logic [3:0] ew_e, input logic stop_e, input string tag);
        for (int i = 0; i < n; i++) begin
            chk_cycle(tag, ns_e, ew_e, stop_e);
            tick();
        end
    endtask

    // Leaves the bench in cycle 0: reset just released, before the first active edge.
    task automatic do_reset();
        rst = 1'b1;
        emergency = 1'b0;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif
        @(posedge clk);
        #2;
        chk_cycle("in_reset", R, R, 1'b0);
        rst = 1'b0;
    endtask

    // Default-parameter free-running cycle: 19 cycles per direction, 38-cycle period.
    function automatic void normal_exp(input int c, output logic [3:0] ns_e, output logic [3:0] ew_e);
        int p;
        p = c % 38;
        ns_e = R;
        ew_e = R;
        if (p >= 2 && p < 6)        ns_e = L;
        else if (p >= 6 && p < 16)  ns_e = G;
        else if (p >= 16 && p < 19) ns_e = Y;
        else if (p >= 21 && p < 25) ew_e = L;
        else if (p >= 25 && p < 35) ew_e = G;
        else if (p >= 35 && p < 38) ew_e = Y;
    endfunction

    initial begin
        logic [3:0] ns_e;
        logic [3:0] ew_e;

        rst = 1'b1;
        emergency = 1'b0;
`ifdef PED_WALK_EN
        ped_req = 1'b0;
`endif

        // Free-running sequence over two full periods.
        do_reset();
        for (int c = 0; c < 78; c++) begin
            normal_exp(c, ns_e, ew_e);
            chk_cycle("normal", ns_e, ew_e, 1'b0);
            tick();
        end

        // One-cycle emergency pulse during NS green.
        do_reset();
        run(2, R, R, 1'b0, "pulse_ar");
        run(4, L, R, 1'b0, "pulse_left");
        run(2, G, R, 1'b0, "pulse_grn");
        emergency = 1'b1;
        run(1, G, R, 1'b0, "pulse_grn8");
        emergency = 1'b0;
        run(3, Y, R, 1'b0, "pulse_yel");
        run(1, R, R, 1'b1, "pulse_pre");
        run(2, R, R, 1'b0, "pulse_ar2");
        run(4, R, L, 1'b0, "pulse_ewleft");
        run(2, R, G, 1'b0, "pulse_ewgrn");

        // Emergency held high for cycles 3..30.
        do_reset();
        run(2, R, R, 1'b0, "hold_ar");
        run(1, L, R, 1'b0, "hold_left2");
        emergency = 1'b1;
        run(1, L, R, 1'b0, "hold_left3");
        run(3, Y, R, 1'b0, "hold_yel");
        run(24, R, R, 1'b1, "hold_pre");
        emergency = 1'b0;
        run(1, R, R, 1'b1, "hold_pre31");
        run(2, R, R, 1'b0, "hold_ar2");
        run(4, R, L, 1'b0, "hold_ewleft");

        // Emergency in ALLRED, then again in the post-preempt ALLRED; direction stays NS.
        do_reset();
        emergency = 1'b1;
        run(1, R, R, 1'b0, "ar_em0");
        emergency = 1'b0;
        run(1, R, R, 1'b1, "ar_pre1");
        emergency = 1'b1;
        run(1, R, R, 1'b0, "ar_em2");
        emergency = 1'b0;
        run(1, R, R, 1'b1, "ar_pre3");
        run(2, R, R, 1'b0, "ar_clear");
        run(4, L, R, 1'b0, "ar_nsleft");
        run(1, G, R, 1'b0, "ar_nsgrn");

        // Asynchronous reset between edges during EW green.
        do_reset();
        for (int c = 0; c < 27; c++) begin
            normal_exp(c, ns_e, ew_e);
            chk_cycle("pre_arst", ns_e, ew_e, 1'b0);
            tick();
        end
        chk_cycle("ew_grn27", R, G, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_cycle("arst_now", R, R, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run(2, R, R, 1'b0, "post_ar");
        run(4, L, R, 1'b0, "post_nsleft");

`ifdef PED_WALK_EN
        // Pedestrian request at cycle 5 -> WALK in cycles 21..26, EW_LEFT from 27.
        do_reset();
        for (int c = 0; c < 31; c++) begin
            if (c == 5) ped_req = 1'b1;
            normal_exp(c, ns_e, ew_e);
            if (c >= 19) ew_e = (c >= 27) ? L : R;
            chk_cycle("ped", ns_e, ew_e, 1'b0);
            chk("ped_walk", {3'b000, walk}, (c >= 21 && c <= 26) ? 4'd1 : 4'd0);
            tick();
            ped_req = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
